call_time_decoder: RTL and testbench
====================================

# call_time_decoder

Receiver for the hourly chime pulse train emitted on `Light`. The chime emits one high pulse per hour, 1 cycle high and 1 cycle low, for the hour count 0..23, then holds low. This block sits on the same clock as the chime. It counts the pulses on the line, detects the end of the train by a low-gap timeout, and returns the announced hour as packed BCD with a one-cycle strobe. It is used for self-check of the alarm clock and for driving a remote hour display from the single chime wire.

## Interface
- `GAP_CYCLES`, default 4: consecutive low samples that end a train. Legal values are 2..15.
- `MAX_HOUR`, default 23: largest legal hour. A count above this is an error.
- `CLK`  input  1  system clock; all logic on the rising edge.
- `RST`  input  1  asynchronous, active-high reset.
- `Light`  input  1  chime line, synchronous to `CLK`; no synchronizer.
- `Hour`  output  8  decoded hour, packed BCD (`[7:4]` tens, `[3:0]` ones).
- `Valid`  output  1  one-cycle strobe: `Hour` was updated this cycle.
- `Error`  output  1  one-cycle strobe: train ended with more than `MAX_HOUR` pulses.
- `Busy`  output  1  high while a train is being received (states HIGH, LOW).

## Operation
- `Light` is sampled at every `CLK` edge. A pulse is a 0→1 transition between consecutive samples. Pulse width is not checked; a multi-cycle high counts as one pulse.
- The pulse counter is 5 bits wide and saturates at 31. The gap counter is 4 bits wide.
- The state machine has four states:
  - **ARM** (the reset state). Wait for `GAP_CYCLES` consecutive low samples, then go to IDLE. A high sample clears the gap counter. This prevents a partial train from being decoded after reset.
  - **IDLE**. A sample of `Light`=1 moves to HIGH with pulse count 1.
  - **HIGH**. A sample of `Light`=0 moves to LOW with gap count 1. A sample of `Light`=1 stays in HIGH.
  - **LOW**. A sample of `Light`=1 moves to HIGH, increments the pulse count (saturating), and clears the gap count. A sample of `Light`=0 increments the gap count. When the gap count reaches `GAP_CYCLES`, the train ends and the state goes to IDLE.
- At train end:
  - If count ≤ `MAX_HOUR`: load `Hour` with BCD(count) and pulse `Valid`.
  - Otherwise: pulse `Error` and leave `Hour` unchanged.
  - In both cases, clear the pulse and gap counters.
- BCD conversion:
  - tens = 2 if count ≥ 20, 1 if count ≥ 10, 0 otherwise.
  - ones = count − 10·tens.
  - Upper tens bits are zero.
- Hour 0 produces no pulses, so nothing is reported. `Hour` retains its previous value.
- `Hour` holds its value between strobes. `Valid` and `Error` are never high in the same cycle.

## Timing
- Reset values: `Hour`=8'h00, `Valid`=0, `Error`=0, `Busy`=0, state ARM, both counters 0.
- Reset asserted mid-train discards the train. No strobe is produced.
- After `RST` is released with `Light` low, the block needs `GAP_CYCLES` edges to reach IDLE.
- Latency: let edge e0 be the first low sample after the last pulse. `Valid` or `Error` is registered at edge e0+`GAP_CYCLES`−1 and is high for exactly one cycle.
- `Busy` goes high the cycle after the first high sample. It falls in the same cycle that `Valid` or `Error` rises.
- Back-to-back trains are allowed:
  - A high sample in IDLE on the cycle right after the strobe starts a new train.
  - A high sample seen while still in LOW with gap < `GAP_CYCLES` continues the current train.
- All outputs are registered. There is no combinational path from `Light` to any output.

## Structure
- The package `call_time_pkg` holds:
  - the state enum `ct_dec_state_t` {ARM, IDLE, HIGH, LOW};
  - `CT_MAX_HOUR` = 23;
  - `CT_CNT_W` = 5;
  - `CT_BCD_W` = 8.
- The sub-module `bin5_to_bcd` is combinational. It converts the 5-bit count to 8-bit BCD and is reusable by the chime encoder side.
- The top level `call_time_decoder` contains the edge detect, the state machine, both counters and the output registers.

## Test plan
- **Hour 12.** Reset, wait for ARM to finish, drive 12 pulses of 1 cycle high and 1 cycle low, then hold low. Required: `Valid`=1 for one cycle at the 4th low sample, `Hour`=8'h12, `Error`=0.
- **Hour 23, then 9.** Drive 23 pulses, then after the strobe drive 9 pulses. Required: `Hour`=8'h23, then 8'h09, with two separate `Valid` strobes.
- **Overflow.** Drive 24 pulses. Required: `Error` for one cycle, no `Valid`, `Hour` keeps the previous value 8'h09. Drive 40 pulses. Required: count saturates, and again only `Error` is reported.
- **Gap threshold.** Drive 3 pulses, 3 low cycles, then 2 pulses. Required: a single `Valid` with `Hour`=8'h05. Drive 3 pulses, 4 low cycles, then 2 pulses. Required: two strobes, `Hour`=8'h03 then 8'h02.
- **Wide pulses.** Drive pulses 3 cycles high and 1 cycle low, ×7. Required: `Hour`=8'h07.
- **Reset mid-train.** Assert `RST` after 5 pulses with `Light` held high through release, then 6 pulses. Required:
  - all outputs at reset values while `RST` is high;
  - no strobe for the partial train;
  - ARM waits for 4 lows;
  - final `Hour`=8'h06.

Source files
------------

// File: rtl/call_time_pkg.sv
// rtl/call_time_pkg.sv - shared types and constants for the chime hour decoder
package call_time_pkg;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } ct_dec_state_t;

    localparam int CT_MAX_HOUR = 23;
    localparam int CT_CNT_W    = 5;
    localparam int CT_BCD_W    = 8;

endpackage

// File: rtl/call_time_decoder_if.sv
// rtl/call_time_decoder_if.sv - chime line in, decoded hour and strobes out
interface call_time_if;
    import call_time_pkg::*;

    logic                Light;
    logic [CT_BCD_W-1:0] Hour;
    logic                Valid;
    logic                Error;
    logic                Busy;

    modport master (output Light, input Hour, input Valid, input Error, input Busy);
    modport slave  (input Light, output Hour, output Valid, output Error, output Busy);

endinterface

// File: rtl/bin5_to_bcd.sv
// rtl/bin5_to_bcd.sv - combinational 5-bit binary to packed two-digit BCD
module bin5_to_bcd
    import call_time_pkg::*;
(
    input  logic [CT_CNT_W-1:0] i_bin,
    output logic [CT_BCD_W-1:0] o_bcd
);

    logic [3:0] w_tens;
    logic [3:0] w_ones;

    always_comb begin
        w_tens = 4'd0;
        w_ones = 4'(i_bin);
        if (i_bin >= 5'd20) begin
            w_tens = 4'd2;
            w_ones = 4'(i_bin - 5'd20);
        end else if (i_bin >= 5'd10) begin
            w_tens = 4'd1;
            w_ones = 4'(i_bin - 5'd10);
        end
    end

    assign o_bcd = {w_tens, w_ones};

endmodule

// File: rtl/call_time_decoder.sv
// rtl/call_time_decoder.sv - counts chime pulses, ends train on a low gap, reports BCD hour
module call_time_decoder
    import call_time_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int MAX_HOUR   = CT_MAX_HOUR
) (
    input  logic        CLK,
    input  logic        RST,
    call_time_if.slave  bus
);

    localparam logic [3:0]          GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [CT_CNT_W-1:0] MAX_N    = CT_CNT_W'(MAX_HOUR);

    ct_dec_state_t       r_state;
    logic [CT_CNT_W-1:0] r_cnt;
    logic [3:0]          r_gap;
    logic                r_light_d;
    logic [CT_BCD_W-1:0] r_hour;
    logic                r_valid;
    logic                r_error;
    logic                r_busy;

    logic                w_rise;
    logic [CT_BCD_W-1:0] w_bcd;

    assign w_rise = bus.Light & ~r_light_d;

    bin5_to_bcd u_bcd (
        .i_bin (r_cnt),
        .o_bcd (w_bcd)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ARM;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_light_d <= 1'b0;
            r_hour    <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_light_d <= bus.Light;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            case (r_state)
                // Holds off decoding until the line has been quiet long enough to be between trains
                ARM: begin
                    if (bus.Light) begin
                        r_gap <= '0;
                    end else if (r_gap == GAP_LAST) begin
                        r_gap   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                IDLE: begin
                    if (w_rise) begin
                        r_state <= HIGH;
                        r_cnt   <= CT_CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (!bus.Light) begin
                        r_state <= LOW;
                        r_gap   <= 4'd1;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        r_state <= HIGH;
                        r_gap   <= '0;
                        r_cnt   <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
                    end else if (r_gap == GAP_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_gap   <= '0;
                        if (r_cnt <= MAX_N) begin
                            r_hour  <= w_bcd;
                            r_valid <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: r_state <= ARM;
            endcase
        end
    end

    assign bus.Hour  = r_hour;
    assign bus.Valid = r_valid;
    assign bus.Error = r_error;
    assign bus.Busy  = r_busy;

endmodule

// File: tb/tb_call_time_decoder.sv
// tb/tb_call_time_decoder.sv - scoreboard bench for call_time_decoder
module tb_call_time_decoder;

    localparam int GAP = 4;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] hour;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   busy_chk = 1'b0;
    exp_t sb[$];

    call_time_if bus_if ();

    call_time_decoder #(.GAP_CYCLES(GAP), .MAX_HOUR(23)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (bus_if.Valid === 1'b1 || bus_if.Error === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got valid=%0b error=%0b hour=%0h expected no strobe (cycle %0d)",
                         bus_if.Valid, bus_if.Error, bus_if.Hour, cyc);
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("error_flag", {31'd0, bus_if.Error}, {31'd0, e.err});
                chk("valid_flag", {31'd0, bus_if.Valid}, {31'd0, !e.err});
                chk("hour", {24'd0, bus_if.Hour}, {24'd0, e.hour});
                chk("busy_at_strobe", {31'd0, bus_if.Busy}, 32'd0);
            end
        end
    end

    task automatic drive(input logic v, output int e);
        @(negedge CLK);
        if (busy_chk) begin
            chk("busy_start", {31'd0, bus_if.Busy}, 32'd1);
            busy_chk = 1'b0;
        end
        bus_if.Light = v;
        e = cyc + 1;
    endtask

    task automatic lows(input int k);
        int e;
        for (int i = 0; i < k; i++) drive(1'b0, e);
    endtask

    // n pulses, each hi samples high separated by single lows; ends on the last high sample
    task automatic pulse_run(input int n, input int hi, input bit start);
        int e;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < hi; j++) begin
                drive(1'b1, e);
                if (start && i == 0 && j == 0) busy_chk = 1'b1;
            end
            if (i < n - 1) drive(1'b0, e);
        end
    endtask

    task automatic finish_train(input bit err, input logic [7:0] hour, input int trail);
        int   e0;
        exp_t x;
        drive(1'b0, e0);
        x.cyc  = e0 + GAP - 1;
        x.err  = err;
        x.hour = hour;
        sb.push_back(x);
        lows(trail);
    endtask

    task automatic check_reset_outputs();
        chk("rst_hour",  {24'd0, bus_if.Hour}, 32'd0);
        chk("rst_valid", {31'd0, bus_if.Valid}, 32'd0);
        chk("rst_error", {31'd0, bus_if.Error}, 32'd0);
        chk("rst_busy",  {31'd0, bus_if.Busy}, 32'd0);
    endtask

    initial begin
        int e;
        bus_if.Light = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs();
        RST = 1'b0;
        lows(GAP - 1);

        pulse_run(12, 1, 1'b1);
        finish_train(1'b0, 8'h12, 5);

        pulse_run(23, 1, 1'b1);
        finish_train(1'b0, 8'h23, 5);
        pulse_run(9, 1, 1'b1);
        finish_train(1'b0, 8'h09, 5);

        pulse_run(24, 1, 1'b1);
        finish_train(1'b1, 8'h09, 5);
        pulse_run(40, 1, 1'b1);
        finish_train(1'b1, 8'h09, 5);

        pulse_run(3, 1, 1'b1);
        lows(3);
        pulse_run(2, 1, 1'b0);
        finish_train(1'b0, 8'h05, 5);

        pulse_run(3, 1, 1'b1);
        finish_train(1'b0, 8'h03, GAP - 1);
        pulse_run(2, 1, 1'b1);
        finish_train(1'b0, 8'h02, 5);

        pulse_run(7, 3, 1'b1);
        finish_train(1'b0, 8'h07, 5);

        pulse_run(5, 1, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check_reset_outputs();
        RST = 1'b0;
        drive(1'b1, e);
        drive(1'b1, e);
        lows(GAP);
        pulse_run(6, 1, 1'b1);
        finish_train(1'b0, 8'h06, 8);

        chk("final_hour", {24'd0, bus_if.Hour}, 32'h06);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
